imem_fetch_buffered: RTL and testbench

//  Next-generation instruction memory. Replaces the single-cycle X/Y-addressed imem.

---
 rtl/imem_fetch_buffered_if.sv | 23 ++
 rtl/imem_fetch_buffered.sv | 190 +++++++++++++++++++
 tb/tb_imem_fetch_buffered.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_buffered_if.sv
// rtl/imem_fetch_buffered_if.sv - fetch request / response handshake bundle for imem_fetch_buffered
interface imem_fetch_buffered_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32
);
    logic          fetch_valid;
    logic          fetch_ready;
    logic [AW-1:0] fetch_addr;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          resp_error;

    modport master (
        output fetch_valid, fetch_addr, resp_ready,
        input  fetch_ready, resp_valid, resp_data, resp_error
    );

    modport slave (
        input  fetch_valid, fetch_addr, resp_ready,
        output fetch_ready, resp_valid, resp_data, resp_error
    );
endinterface

// File: rtl/imem_fetch_buffered.sv
// rtl/imem_fetch_buffered.sv - self-initialising row/column instruction memory with buffered fetch port
// Optional per-byte even parity and error injection under `IMEM_PARITY_EN.
module imem_fetch_buffered #(
    parameter int unsigned            ROW_BITS   = 4,
    parameter int unsigned            COL_BITS   = 4,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            NUM_WORDS  = 256,
    parameter int unsigned            RESP_DEPTH = 3,
    parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    output logic                              init_busy_o,
    imem_fetch_buffered_if.slave              fetch_if,
    input  logic                              wr_en_i,
    input  logic [ROW_BITS+COL_BITS-1:0]      wr_addr_i,
    input  logic [DATA_WIDTH-1:0]             wr_data_i,
    input  logic [DATA_WIDTH/8-1:0]           wr_be_i
`ifdef IMEM_PARITY_EN
    ,
    input  logic                              inj_par_err_i
`endif
);
    localparam int unsigned AW = ROW_BITS + COL_BITS;
    localparam int unsigned BW = DATA_WIDTH / 8;
    localparam int unsigned IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned PW = $clog2(RESP_DEPTH);
    localparam int unsigned CW = $clog2(RESP_DEPTH + 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                  state_q;
    logic                    init_busy_q;
    logic [IW-1:0]           init_addr_q;

    logic [DATA_WIDTH-1:0]   mem_q [NUM_WORDS];
`ifdef IMEM_PARITY_EN
    logic [BW-1:0]           par_q [NUM_WORDS];
`endif

    logic                    inflight_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic                    rd_err_q;

    logic [DATA_WIDTH-1:0]   fifo_data_q [RESP_DEPTH];
    logic                    fifo_err_q  [RESP_DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;

    logic [ROW_BITS-1:0]     fetch_row;
    logic [COL_BITS-1:0]     fetch_col;
    logic [AW-1:0]           fetch_flat;
    logic [IW-1:0]           fetch_idx;
    logic [IW-1:0]           wr_idx;
    logic                    fetch_in_range;
    logic                    wr_in_range;
    logic                    fetch_accept;
    logic                    push;
    logic                    pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (32'(p) == RESP_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [BW-1:0] byte_parity(input logic [DATA_WIDTH-1:0] w);
        logic [BW-1:0] p;
        p = '0;
        for (int b = 0; b < int'(BW); b++) begin
            p[b] = ^w[8*b +: 8];
        end
        return p;
    endfunction

    // X selects the row, Y the column; the array itself is stored flat.
    assign fetch_row      = fetch_if.fetch_addr[AW-1:COL_BITS];
    assign fetch_col      = fetch_if.fetch_addr[COL_BITS-1:0];
    assign fetch_flat     = {fetch_row, fetch_col};
    assign fetch_idx      = fetch_flat[IW-1:0];
    assign wr_idx         = wr_addr_i[IW-1:0];
    assign fetch_in_range = 32'(fetch_flat) < NUM_WORDS;
    assign wr_in_range    = 32'(wr_addr_i) < NUM_WORDS;

    // Only registered terms here, so resp_ready never reaches fetch_ready.
    assign fetch_if.fetch_ready = !init_busy_q &&
                                  ((32'(count_q) + 32'(inflight_q)) < RESP_DEPTH);
    assign fetch_accept = fetch_if.fetch_valid && fetch_if.fetch_ready;

    assign push = inflight_q;
    assign pop  = fetch_if.resp_valid && fetch_if.resp_ready;

    assign fetch_if.resp_valid = (count_q != '0);
    assign fetch_if.resp_data  = fifo_data_q[rd_ptr_q];
    assign fetch_if.resp_error = fifo_err_q[rd_ptr_q];
    assign init_busy_o         = init_busy_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_INIT;
            init_busy_q <= 1'b1;
            init_addr_q <= '0;
            inflight_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < int'(RESP_DEPTH); i++) begin
                fifo_data_q[i] <= '0;
                fifo_err_q[i]  <= 1'b0;
            end
        end else begin
            case (state_q)
                S_INIT: begin
                    if (32'(init_addr_q) == NUM_WORDS - 1) begin
                        state_q     <= S_RUN;
                        init_busy_q <= 1'b0;
                    end else begin
                        init_addr_q <= init_addr_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_RUN;
                    init_busy_q <= 1'b0;
                end
            endcase
            inflight_q <= fetch_accept;
            if (push) begin
                fifo_data_q[wr_ptr_q] <= rd_data_q;
                fifo_err_q[wr_ptr_q]  <= rd_err_q;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Array and read stage carry no reset; nonblocking read gives read-before-write.
    always_ff @(posedge clk_i) begin
        if (init_busy_q) begin
            mem_q[init_addr_q] <= INIT_VALUE;
`ifdef IMEM_PARITY_EN
            par_q[init_addr_q] <= byte_parity(INIT_VALUE);
`endif
        end else if (wr_en_i && wr_in_range) begin
            for (int b = 0; b < int'(BW); b++) begin
                if (wr_be_i[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
`ifdef IMEM_PARITY_EN
            for (int b = 1; b < int'(BW); b++) begin
                if (wr_be_i[b]) begin
                    par_q[wr_idx][b] <= ^wr_data_i[8*b +: 8];
                end
            end
            if (wr_be_i[0]) begin
                par_q[wr_idx][0] <= (^wr_data_i[7:0]) ^ inj_par_err_i;
            end else if (inj_par_err_i) begin
                par_q[wr_idx][0] <= ~par_q[wr_idx][0];
            end
`endif
        end

        if (fetch_accept) begin
            if (fetch_in_range) begin
                rd_data_q <= mem_q[fetch_idx];
`ifdef IMEM_PARITY_EN
                rd_err_q  <= |(byte_parity(mem_q[fetch_idx]) ^ par_q[fetch_idx]);
`else
                rd_err_q  <= 1'b0;
`endif
            end else begin
                rd_data_q <= '0;
                rd_err_q  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_imem_fetch_buffered.sv
// tb/tb_imem_fetch_buffered.sv - self-checking bench for imem_fetch_buffered
module tb_imem_fetch_buffered;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_fetch_buffered_if #(.AW(AW), .DW(DW)) bus ();
    imem_fetch_buffered_if #(.AW(AW), .DW(DW)) bus2 ();

    logic          init_busy, init_busy2;
    logic          wr_en, wr_en2;
    logic [AW-1:0] wr_addr, wr_addr2;
    logic [DW-1:0] wr_data, wr_data2;
    logic [BW-1:0] wr_be, wr_be2;
    logic          inj, inj2;

    imem_fetch_buffered dut (
        .clk_i(clk), .rst_n_i(rst_n), .init_busy_o(init_busy), .fetch_if(bus),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be)
`ifdef IMEM_PARITY_EN
        , .inj_par_err_i(inj)
`endif
    );

    imem_fetch_buffered #(.NUM_WORDS(200)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .init_busy_o(init_busy2), .fetch_if(bus2),
        .wr_en_i(wr_en2), .wr_addr_i(wr_addr2), .wr_data_i(wr_data2), .wr_be_i(wr_be2)
`ifdef IMEM_PARITY_EN
        , .inj_par_err_i(inj2)
`endif
    );

    typedef struct { logic [31:0] data; logic err; } exp_t;
    typedef struct {
        bit wr; logic [7:0] waddr; logic [31:0] wdata; logic [3:0] be;
        bit rd; logic [7:0] raddr; logic [31:0] exp; logic err;
    } vec_t;

    exp_t        sb_q[$];
    logic [31:0] model_mem [256];
    logic        model_perr [256];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_acc = 0;
    vec_t        vt [16];
    logic [7:0]  stall_addrs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 32'h0;
            model_perr[i] = 1'b0;
        end
        sb_q.delete();
    endtask

    task automatic cycle(input bit use_tbl = 1'b0, input logic [31:0] tdata = 32'h0,
                         input logic terr = 1'b0);
        exp_t e;
        @(negedge clk);
        if (bus.resp_valid && bus.resp_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL resp_unexpected: got %0h expected no response", bus.resp_data);
            end else begin
                e = sb_q.pop_front();
                check("resp_data", {32'h0, bus.resp_data}, {32'h0, e.data});
                check("resp_error", {63'h0, bus.resp_error}, {63'h0, e.err});
            end
        end
        if (bus.fetch_valid && bus.fetch_ready) begin
            n_acc++;
            if (use_tbl) begin
                e.data = tdata;
                e.err  = terr;
            end else begin
                e.data = model_mem[bus.fetch_addr];
                e.err  = model_perr[bus.fetch_addr];
            end
            sb_q.push_back(e);
        end
        if (wr_en && !init_busy) begin
            for (int b = 0; b < BW; b++) begin
                if (wr_be[b]) model_mem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
            end
            model_perr[wr_addr] = wr_be[0] ? inj : (model_perr[wr_addr] ^ inj);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb_q.size() > 0 && k < 30) begin
            cycle();
            k++;
        end
        check(name, {32'h0, 32'(sb_q.size())}, 64'h0);
        cycle();
        cycle();
    endtask

    task automatic wait_init(input string name);
        int  n;
        bit  ready_seen;
        n = 0;
        ready_seen = 1'b0;
        while (init_busy && n < 1000) begin
            if (bus.fetch_ready) ready_seen = 1'b1;
            cycle();
            n++;
        end
        check({name, "_cycles"}, {32'h0, 32'(n)}, 64'd256);
        check({name, "_ready_low"}, {63'h0, ready_seen}, 64'h0);
    endtask

    task automatic fetch2(input logic [7:0] a, input logic [31:0] ed, input logic ee);
        int k;
        bus2.fetch_valid = 1'b1;
        bus2.fetch_addr  = a;
        k = 0;
        while (!bus2.fetch_ready && k < 50) begin cycle(); k++; end
        check("t5_ready", {63'h0, bus2.fetch_ready}, 64'h1);
        cycle();
        bus2.fetch_valid = 1'b0;
        k = 0;
        while (!bus2.resp_valid && k < 50) begin cycle(); k++; end
        check("t5_valid", {63'h0, bus2.resp_valid}, 64'h1);
        check("t5_data", {32'h0, bus2.resp_data}, {32'h0, ed});
        check("t5_error", {63'h0, bus2.resp_error}, {63'h0, ee});
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{0, 8'h00, 32'h0,        4'h0, 1, 8'h00, 32'h00000000, 1'b0};
        vt[1]  = '{1, 8'h3C, 32'hDEADBEEF, 4'hF, 0, 8'h00, 32'h0,        1'b0};
        vt[2]  = '{1, 8'h3C, 32'h00000011, 4'h1, 0, 8'h00, 32'h0,        1'b0};
        vt[3]  = '{0, 8'h00, 32'h0,        4'h0, 1, 8'h3C, 32'hDEADBE11, 1'b0};
        vt[4]  = '{1, 8'h10, 32'hA5A5A5A5, 4'hF, 0, 8'h00, 32'h0,        1'b0};
        vt[5]  = '{1, 8'h10, 32'h0000FF00, 4'h2, 0, 8'h00, 32'h0,        1'b0};
        vt[6]  = '{0, 8'h00, 32'h0,        4'h0, 1, 8'h10, 32'hA5A5FFA5, 1'b0};
        vt[7]  = '{1, 8'h10, 32'h77000000, 4'h8, 1, 8'h10, 32'hA5A5FFA5, 1'b0};
        vt[8]  = '{0, 8'h00, 32'h0,        4'h0, 1, 8'h10, 32'h77A5FFA5, 1'b0};
        vt[9]  = '{1, 8'hFF, 32'h12345678, 4'hC, 0, 8'h00, 32'h0,        1'b0};
        vt[10] = '{0, 8'h00, 32'h0,        4'h0, 1, 8'hFF, 32'h12340000, 1'b0};
        vt[11] = '{1, 8'h20, 32'hFFFFFFFF, 4'h0, 1, 8'h20, 32'h00000000, 1'b0};
        vt[12] = '{0, 8'h00, 32'h0,        4'h0, 1, 8'h20, 32'h00000000, 1'b0};
        vt[13] = '{1, 8'h05, 32'hCAFEF00D, 4'hF, 0, 8'h00, 32'h0,        1'b0};
        vt[14] = '{1, 8'h05, 32'h12345678, 4'hF, 1, 8'h05, 32'hCAFEF00D, 1'b0};
        vt[15] = '{0, 8'h00, 32'h0,        4'h0, 1, 8'h05, 32'h12345678, 1'b0};
        stall_addrs = '{8'h3C, 8'h10, 8'h05, 8'hFF, 8'h00, 8'h20};

        bus.fetch_valid = 0; bus.fetch_addr = '0; bus.resp_ready = 1;
        bus2.fetch_valid = 0; bus2.fetch_addr = '0; bus2.resp_ready = 1;
        wr_en = 0; wr_addr = '0; wr_data = '0; wr_be = '0; inj = 0;
        wr_en2 = 0; wr_addr2 = '0; wr_data2 = '0; wr_be2 = '0; inj2 = 0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_init_busy", {63'h0, init_busy}, 64'h1);
        check("rst_fetch_ready", {63'h0, bus.fetch_ready}, 64'h0);
        check("rst_resp_valid", {63'h0, bus.resp_valid}, 64'h0);
        check("rst_resp_data", {32'h0, bus.resp_data}, 64'h0);
        check("rst_resp_error", {63'h0, bus.resp_error}, 64'h0);
        rst_n = 1'b1;
        wait_init("init");

        for (int i = 0; i < 16; i++) begin
            wr_en = vt[i].wr; wr_addr = vt[i].waddr; wr_data = vt[i].wdata; wr_be = vt[i].be;
            bus.fetch_valid = vt[i].rd; bus.fetch_addr = vt[i].raddr;
            if (vt[i].rd) check("tbl_fetch_ready", {63'h0, bus.fetch_ready}, 64'h1);
            cycle(vt[i].rd, vt[i].exp, vt[i].err);
        end
        wr_en = 0; bus.fetch_valid = 0;
        drain("tbl_drain");

        bus.fetch_valid = 1; bus.fetch_addr = 8'h3C;
        cycle();
        bus.fetch_valid = 0;
        check("lat_not_yet", {63'h0, bus.resp_valid}, 64'h0);
        cycle();
        check("lat_valid", {63'h0, bus.resp_valid}, 64'h1);
        check("lat_data", {32'h0, bus.resp_data}, 64'hDEADBE11);
        drain("lat_drain");

        bus.resp_ready = 0; bus.fetch_valid = 1; n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            bus.fetch_addr = stall_addrs[i];
            cycle();
            if (bus.resp_valid && sb_q.size() > 0)
                check("stall_stable", {32'h0, bus.resp_data}, {32'h0, sb_q[0].data});
        end
        check("stall_accepts", {32'h0, 32'(n_acc)}, 64'd3);
        check("stall_ready_low", {63'h0, bus.fetch_ready}, 64'h0);
        bus.fetch_valid = 0; bus.resp_ready = 1;
        drain("stall_drain");

        bus.fetch_valid = 1; n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            bus.fetch_addr = 8'($urandom_range(0, 255));
            cycle();
        end
        check("steady_accepts", {32'h0, 32'(n_acc)}, 64'd10);
        bus.fetch_valid = 0;
        drain("steady_drain");

        wr_en2 = 1; wr_addr2 = 8'hC8; wr_data2 = 32'hAAAAAAAA; wr_be2 = 4'hF;
        cycle();
        wr_addr2 = 8'h48; wr_data2 = 32'h5555AAAA;
        cycle();
        wr_en2 = 0;
        fetch2(8'hC8, 32'h0, 1'b1);
        fetch2(8'hFF, 32'h0, 1'b1);
        fetch2(8'hC7, 32'h0, 1'b0);
        fetch2(8'h00, 32'h0, 1'b0);
        fetch2(8'h48, 32'h5555AAAA, 1'b0);

`ifdef IMEM_PARITY_EN
        wr_en = 1; wr_addr = 8'h30; wr_data = 32'h01020304; wr_be = 4'hF; inj = 1;
        cycle();
        wr_en = 0; inj = 0;
        bus.fetch_valid = 1; bus.fetch_addr = 8'h30;
        cycle(1'b1, 32'h01020304, 1'b1);
        bus.fetch_valid = 0;
        drain("par_drain");
`endif

        bus.resp_ready = 0; bus.fetch_valid = 1; bus.fetch_addr = 8'h3C;
        cycle();
        bus.fetch_addr = 8'h05;
        cycle();
        bus.fetch_valid = 0;
        cycle();
        check("mid_queued", {63'h0, bus.resp_valid}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_resp_valid", {63'h0, bus.resp_valid}, 64'h0);
        check("mid_init_busy", {63'h0, init_busy}, 64'h1);
        check("mid_fetch_ready", {63'h0, bus.fetch_ready}, 64'h0);
        model_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
        bus.resp_ready = 1;
        wait_init("reinit");
        bus.fetch_valid = 1;
        for (int i = 0; i < 6; i++) begin
            bus.fetch_addr = stall_addrs[i];
            cycle(1'b1, 32'h0, 1'b0);
        end
        bus.fetch_addr = 8'h30;
        cycle(1'b1, 32'h0, 1'b0);
        bus.fetch_valid = 0;
        drain("reinit_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
